// File: rtl/decoder_pkg.sv
// Shared constants and the one-hot helper for the decoder block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package decoder_pkg;

  // Default width of the binary select; legal range is 1..8.
  localparam int DEFAULT_ENCODE_WIDTH = 4;
  localparam int MAX_ENCODE_WIDTH     = 8;
  localparam int MAX_DECODE_WIDTH     = 1 << MAX_ENCODE_WIDTH;

  // Returns 1 << idx at the widest supported decode width. Callers cast the
  // result down to their own DECODE_WIDTH, so one function serves every
  // ENCODE_WIDTH. A shift by an X/Z amount yields all-X in 4-state
  // simulation, so unknown selects are never silently decoded.
  function automatic logic [MAX_DECODE_WIDTH-1:0] onehot(input logic [MAX_ENCODE_WIDTH-1:0] idx);
    return {{(MAX_DECODE_WIDTH-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Pure combinational binary-to-one-hot decode.
// Latency: zero cycles, no state.
// Backpressure: none; the output always follows idx_i.
//
// Ports:
//   idx_i  binary index, ENCODE_WIDTH bits
//   dec_o  one-hot decode, DECODE_WIDTH bits
module decoder_core
  import decoder_pkg::*;
#(
  parameter int  ENCODE_WIDTH = DEFAULT_ENCODE_WIDTH,
  localparam int DECODE_WIDTH = 1 << ENCODE_WIDTH
) (
  input  logic [ENCODE_WIDTH-1:0] idx_i,
  output logic [DECODE_WIDTH-1:0] dec_o
);

  // Zero-extend to the helper's index width; X bits survive the extension so
  // an unknown select still produces an all-X decode.
  assign dec_o = DECODE_WIDTH'(onehot(MAX_ENCODE_WIDTH'(idx_i)));

endmodule

// File: rtl/decoder.sv
// Binary-to-one-hot decoder with a combinational output and a registered copy.
// Latency: out is zero-cycle; out_q/out_vld (and hist) update one clk after en.
// Backpressure: none; en captures unconditionally, clr wins over en.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   in          binary index to decode
//   en, clr     capture enable / synchronous clear of the registered path
//   out         combinational one-hot of in
//   out_q       registered one-hot, out_vld set once a capture has happened
//   hist        sticky OR of all captures (only with DECODER_HIST_EN defined)
//
// Build option: define DECODER_HIST_EN to add the hist port and its register.
module decoder
  import decoder_pkg::*;
#(
  parameter int  ENCODE_WIDTH = DEFAULT_ENCODE_WIDTH,
  localparam int DECODE_WIDTH = 1 << ENCODE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ENCODE_WIDTH-1:0] in,
  input  logic                    en,
  input  logic                    clr,
  output logic [DECODE_WIDTH-1:0] out,
  output logic [DECODE_WIDTH-1:0] out_q,
  output logic                    out_vld
`ifdef DECODER_HIST_EN
  ,
  output logic [DECODE_WIDTH-1:0] hist
`endif
);

  logic [DECODE_WIDTH-1:0] dec;
  logic [DECODE_WIDTH-1:0] dec_d, dec_q;
  logic                    vld_d, vld_q;

  decoder_core #(
    .ENCODE_WIDTH(ENCODE_WIDTH)
  ) u_core (
    .idx_i(in),
    .dec_o(dec)
  );

  // The combinational path depends on in only; reset, en and clr never touch it.
  assign out     = dec;
  assign out_q   = dec_q;
  assign out_vld = vld_q;

`ifdef DECODER_HIST_EN
  logic [DECODE_WIDTH-1:0] hist_d, hist_q;
  assign hist = hist_q;
`endif

  always_comb begin
    dec_d = dec_q;
    vld_d = vld_q;
`ifdef DECODER_HIST_EN
    hist_d = hist_q;
`endif
    // clr is checked first so it overrides a simultaneous capture.
    if (clr) begin
      dec_d = '0;
      vld_d = 1'b0;
`ifdef DECODER_HIST_EN
      hist_d = '0;
`endif
    end else if (en) begin
      dec_d = dec;
      vld_d = 1'b1;
`ifdef DECODER_HIST_EN
      hist_d = hist_q | dec;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= '0;
      vld_q <= 1'b0;
`ifdef DECODER_HIST_EN
      hist_q <= '0;
`endif
    end else begin
      dec_q <= dec_d;
      vld_q <= vld_d;
`ifdef DECODER_HIST_EN
      hist_q <= hist_d;
`endif
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder at ENCODE_WIDTH=4 and ENCODE_WIDTH=1.
// Expected values come from a behavioural model built on 2**index arithmetic.
// Directed scenarios first, then a randomized run against the same model.
module tb_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  in;
  logic        en, clr;
  logic [15:0] out, out_q;
  logic        out_vld;

  logic        in1, en1, clr1;
  logic [1:0]  out1, out_q1;
  logic        out_vld1;

`ifdef DECODER_HIST_EN
  logic [15:0] hist;
  logic [1:0]  hist1;
  logic [15:0] m_hist;
  logic [1:0]  m1_hist;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [15:0] m_q;
  logic        m_vld;
  logic [1:0]  m1_q;
  logic        m1_vld;

  decoder #(.ENCODE_WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in(in), .en(en), .clr(clr),
    .out(out), .out_q(out_q), .out_vld(out_vld)
`ifdef DECODER_HIST_EN
    , .hist(hist)
`endif
  );

  decoder #(.ENCODE_WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .en(en1), .clr(clr1),
    .out(out1), .out_q(out_q1), .out_vld(out_vld1)
`ifdef DECODER_HIST_EN
    , .hist(hist1)
`endif
  );

  function automatic logic [15:0] ref_dec(input int idx);
    return 16'(2 ** idx);
  endfunction

  function automatic logic [1:0] ref_dec1(input int idx);
    return 2'(2 ** idx);
  endfunction

  task automatic model_reset();
    m_q = '0; m_vld = 1'b0; m1_q = '0; m1_vld = 1'b0;
`ifdef DECODER_HIST_EN
    m_hist = '0; m1_hist = '0;
`endif
  endtask

  // Advance one clock, apply the capture rules to the model, settle 1 time unit.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (clr) begin
        m_q = '0; m_vld = 1'b0;
`ifdef DECODER_HIST_EN
        m_hist = '0;
`endif
      end else if (en) begin
        m_q = ref_dec(int'(in)); m_vld = 1'b1;
`ifdef DECODER_HIST_EN
        m_hist = m_hist | ref_dec(int'(in));
`endif
      end
      if (clr1) begin
        m1_q = '0; m1_vld = 1'b0;
`ifdef DECODER_HIST_EN
        m1_hist = '0;
`endif
      end else if (en1) begin
        m1_q = ref_dec1(int'(in1)); m1_vld = 1'b1;
`ifdef DECODER_HIST_EN
        m1_hist = m1_hist | ref_dec1(int'(in1));
`endif
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; in = 4'd5;
    in1 = 1'b0; en1 = 1'b0; clr1 = 1'b0;
    model_reset();
    #2;
    vectors++;
    if ({out_q, out_vld} !== {16'h0000, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: out_q=%h out_vld=%b, want 0000/0", out_q, out_vld);
    end
    vectors++;
    if (out !== 16'h0020) begin
      miscompares++;
      $display("FAIL out_in_reset: out=%h, want 0020", out);
    end
    tick();
    tick();
    // Release away from the edge; the first capture is the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({out_q, out_vld} !== {16'h0000, 1'b0}) begin
      miscompares++;
      $display("FAIL pre_first_capture: out_q=%h out_vld=%b, want 0000/0", out_q, out_vld);
    end
    tick();
    vectors++;
    if ({out_q, out_vld} !== {16'h0020, 1'b1}) begin
      miscompares++;
      $display("FAIL first_capture: out_q=%h out_vld=%b, want 0020/1", out_q, out_vld);
    end
  endtask

  // Combinational decode sweep with clr held high and en toggling:
  // out must follow in on the same cycle regardless of the control inputs.
  task automatic test_comb_sweep();
    clr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in = 4'(i);
      en = i[0];
      #1;
      vectors++;
      if (out !== ref_dec(i)) begin
        miscompares++;
        $display("FAIL comb_sweep[%0d]: out=%h, want %h", i, out, ref_dec(i));
      end
      tick();
    end
    clr = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_capture_hold();
    en = 1'b1; in = 4'd3;
    tick();
    vectors++;
    if (out_q !== 16'h0008) begin
      miscompares++;
      $display("FAIL capture3: out_q=%h, want 0008", out_q);
    end
    en = 1'b0; in = 4'd9;
    #1;
    vectors++;
    if ({out, out_q} !== {16'h0200, 16'h0008}) begin
      miscompares++;
      $display("FAIL hold_comb: out=%h out_q=%h, want 0200/0008", out, out_q);
    end
    tick();
    tick();
    vectors++;
    if ({out_q, out_vld} !== {16'h0008, 1'b1}) begin
      miscompares++;
      $display("FAIL hold_reg: out_q=%h out_vld=%b, want 0008/1", out_q, out_vld);
    end
  endtask

  // Captures 1, 4, 15 then asserts en and clr together; clr must win.
  task automatic test_clr_priority();
    clr = 1'b1; en = 1'b1;
    tick();
    clr = 1'b0;
    in = 4'd1;  tick();
    in = 4'd4;  tick();
    in = 4'd15; tick();
    vectors++;
    if ({out_q, out_vld} !== {16'h8000, 1'b1}) begin
      miscompares++;
      $display("FAIL msb_capture: out_q=%h out_vld=%b, want 8000/1", out_q, out_vld);
    end
`ifdef DECODER_HIST_EN
    vectors++;
    if (hist !== 16'h8012) begin
      miscompares++;
      $display("FAIL hist_accum: hist=%h, want 8012", hist);
    end
`endif
    in = 4'd7; en = 1'b1; clr = 1'b1;
    tick();
    vectors++;
    if ({out_q, out_vld} !== {16'h0000, 1'b0}) begin
      miscompares++;
      $display("FAIL clr_priority: out_q=%h out_vld=%b, want 0000/0", out_q, out_vld);
    end
`ifdef DECODER_HIST_EN
    vectors++;
    if (hist !== 16'h0000) begin
      miscompares++;
      $display("FAIL hist_clr: hist=%h, want 0000", hist);
    end
`endif
    clr = 1'b0; en = 1'b0;
  endtask

  task automatic test_async_reset();
    en = 1'b1; in = 4'd6;
    tick();
    en = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    in = 4'd11;
    #1;
    vectors++;
    if ({out_q, out_vld} !== {16'h0000, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: out_q=%h out_vld=%b, want 0000/0", out_q, out_vld);
    end
`ifdef DECODER_HIST_EN
    vectors++;
    if (hist !== 16'h0000) begin
      miscompares++;
      $display("FAIL async_reset_hist: hist=%h, want 0000", hist);
    end
`endif
    vectors++;
    if (out !== 16'h0800) begin
      miscompares++;
      $display("FAIL out_track_reset: out=%h, want 0800", out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_width1();
    in1 = 1'b1; en1 = 1'b0; clr1 = 1'b0;
    #1;
    vectors++;
    if ({out1, out_q1} !== {2'b10, 2'b00}) begin
      miscompares++;
      $display("FAIL w1_comb: out=%b out_q=%b, want 10/00", out1, out_q1);
    end
    en1 = 1'b1;
    tick();
    en1 = 1'b0;
    in1 = 1'b0;
    #1;
    vectors++;
    if ({out1, out_q1, out_vld1} !== {2'b01, 2'b10, 1'b1}) begin
      miscompares++;
      $display("FAIL w1_capture: out=%b out_q=%b vld=%b, want 01/10/1", out1, out_q1, out_vld1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      in   = 4'($urandom_range(0, 15));
      en   = ($urandom_range(0, 1) == 1);
      clr  = ($urandom_range(0, 7) == 0);
      in1  = 1'($urandom_range(0, 1));
      en1  = ($urandom_range(0, 1) == 1);
      clr1 = ($urandom_range(0, 7) == 0);
      #1;
      vectors++;
      if ({out, out1} !== {ref_dec(int'(in)), ref_dec1(int'(in1))}) begin
        miscompares++;
        $display("FAIL rnd_comb[%0d]: out=%h out1=%b, want %h/%b", n, out, out1,
                 ref_dec(int'(in)), ref_dec1(int'(in1)));
      end
      tick();
      vectors++;
      if ({out_q, out_vld, out_q1, out_vld1} !== {m_q, m_vld, m1_q, m1_vld}) begin
        miscompares++;
        $display("FAIL rnd_reg[%0d]: out_q=%h vld=%b q1=%b vld1=%b, want %h/%b/%b/%b",
                 n, out_q, out_vld, out_q1, out_vld1, m_q, m_vld, m1_q, m1_vld);
      end
`ifdef DECODER_HIST_EN
      vectors++;
      if ({hist, hist1} !== {m_hist, m1_hist}) begin
        miscompares++;
        $display("FAIL rnd_hist[%0d]: hist=%h hist1=%b, want %h/%b", n, hist, hist1, m_hist, m1_hist);
      end
`endif
    end
    en = 1'b0; clr = 1'b0; en1 = 1'b0; clr1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_comb_sweep();
    test_capture_hold();
    test_clr_priority();
    test_async_reset();
    test_width1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameter ENCODE_WIDTH, default 4: width of the binary select input; legal range 1..8.
REQ-002 Parameter DECODE_WIDTH, default 2**ENCODE_WIDTH: one-hot output width; derived, never overridden independently.
REQ-003 clk  input  1  single clock; all registers update on its rising edge.
REQ-004 rst_n  input  1  reset is asynchronous and active-low.
REQ-005 in  input  ENCODE_WIDTH  binary index to decode.
REQ-006 en  input  1  capture enable for the registered path.
REQ-007 clr  input  1  synchronous clear of registered outputs and history.
REQ-008 out  output  DECODE_WIDTH  combinational one-hot decode of in.
REQ-009 out_q  output  DECODE_WIDTH  registered one-hot decode.
REQ-010 out_vld  output  1  out_q holds a captured decode.
REQ-011 hist  output  DECODE_WIDTH  sticky OR of all captured decodes; present only with DECODER_HIST_EN.

Function
REQ-012 out SHALL equal 1 << in at all times, zero latency, independent of clk, rst_n, en and clr.
REQ-013 out SHALL have exactly one bit set for every in value 0..DECODE_WIDTH-1; bit i is set iff in == i.
REQ-014 An X/Z bit on in SHALL drive out to all-X in simulation (no silent default).
REQ-015 On a rising clk with clr=1, out_q, out_vld and hist SHALL become 0, regardless of en.
REQ-016 On a rising clk with clr=0 and en=1, out_q SHALL load 1 << in and out_vld SHALL become 1: one-cycle latency.
REQ-017 On a rising clk with clr=0 and en=0, out_q and out_vld SHALL hold their values.
REQ-018 hist SHALL OR in the newly captured decode on every en=1, clr=0 edge; set bits stay set until clr or reset.
REQ-019 clr SHALL take priority over en when both are 1 in the same cycle.
REQ-020 in = DECODE_WIDTH-1 (all ones) SHALL set the MSB of out and out_q; no wrap or overflow.
REQ-021 Inputs en, clr and rst_n left unconnected SHALL NOT affect out.

Reset
REQ-022 rst_n low SHALL immediately clear out_q, out_vld and hist to 0, asynchronously.
REQ-023 Release of rst_n SHALL be treated synchronously to clk; the first capture occurs at the first rising edge with rst_n high.
REQ-024 Reset asserted mid-operation SHALL discard any held capture; out SHALL keep tracking in throughout reset.

Configuration
REQ-025 Macro DECODER_HIST_EN: when defined, the hist port and its register SHALL exist per REQ-018.
REQ-026 When DECODER_HIST_EN is not defined, the hist port and its register SHALL be absent; all other behaviour is unchanged.

Structure
REQ-027 A shared package decoder_pkg SHALL hold the default ENCODE_WIDTH constant and a function onehot(idx) that returns 1 << idx at DECODE_WIDTH bits.
REQ-028 A sub-module decoder_core SHALL implement the pure combinational decode.
REQ-029 decoder SHALL instantiate decoder_core once, drive out from it, and register its result for out_q.

Verification
REQ-030 Sweep in = 0..15 at ENCODE_WIDTH=4, one value per clk, en/clr/rst_n unconnected -> out = 1,2,4,...,32768 on the same cycle.
REQ-031 Apply rst_n=0, then release; set en=1 with in=5 -> out_q=0x0020 and out_vld=1 one cycle later; before that edge out_q=0 and out_vld=0.
REQ-032 Capture in=3, then en=0 while in changes to 9 -> out_q holds 0x0008 and out becomes 0x0200.
REQ-033 With hist enabled, capture in=1, 4, 15, then set en=1 and clr=1 together -> hist=0x8012 before the clear, then 0 along with out_q and out_vld.
REQ-034 Assert rst_n low mid-cycle after a capture -> out_q, out_vld and hist are 0 before the next clk edge.
REQ-035 Run with ENCODE_WIDTH=1 and in=1 -> out=2'b10, and out_q=2'b10 after a capture.
